// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: frame constants, receiver states and the frame check.
package ps2_pkg;

    localparam int         PS2_FRAME_BITS = 11;
    localparam logic [7:0] PS2_BREAK      = 8'hF0;
    localparam logic [7:0] PS2_EXT        = 8'hE0;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CHECK
    } rx_state_t;

    // Frame payload is {stop, parity, data[7:0]}. Odd parity over data+parity, stop high.
    function automatic logic frame_good(input logic [9:0] frame);
        return (^frame[8:0]) & frame[9];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; a pop in the same cycle frees room for a push when full.
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0]  mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic                do_wr;
    logic                do_rd;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign do_rd = rd_en & ~empty;
    assign do_wr = wr_en & (~full | do_rd);
    assign dout  = mem[rd_ptr[DEPTH_LOG2-1:0]];

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_rd)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= din;
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronise, deserialise and check frames, queue good codes for the decoder.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH_LOG2 = 3,
    parameter int TIMEOUT    = 100000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow,
    output logic       frame_err
);

    localparam logic [16:0] TMO_MAX  = 17'(TIMEOUT);
    localparam logic [3:0]  LAST_BIT = 4'(PS2_FRAME_BITS - 1);

    rx_state_t   state;
    rx_state_t   state_next;
    logic [2:0]  clk_sync;
    logic [2:0]  data_sync;
    logic        fall;
    logic        din;
    logic [3:0]  bitcnt;
    logic [9:0]  shreg;
    logic [16:0] tcnt;
    logic        err_next;
    logic        push;
    logic        pop;
    logic        nd_prev;
    logic        full;
    logic        empty;
    logic [7:0]  head;

    // Index 0 is the pin-side flop; a falling edge is the older stage high and the newer low.
    assign fall = clk_sync[2] & ~clk_sync[1];
    assign din  = data_sync[2];
    assign pop  = nd_prev & ~nextdata_n & ~empty;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            clk_sync  <= '0;
            data_sync <= '0;
        end else begin
            clk_sync  <= {clk_sync[1:0], ps2_clk};
            data_sync <= {data_sync[1:0], ps2_data};
        end
    end

    always_comb begin
        state_next = state;
        err_next   = 1'b0;
        push       = 1'b0;
        case (state)
            IDLE:  if (fall && !din) state_next = SHIFT;
            SHIFT: begin
                if (fall) begin
                    if (bitcnt == LAST_BIT) state_next = CHECK;
                end else if (tcnt == TMO_MAX) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end
            end
            CHECK: begin
                state_next = IDLE;
                if (frame_good(shreg)) push = 1'b1;
                else                   err_next = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= IDLE;
            bitcnt    <= '0;
            tcnt      <= '0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
            nd_prev   <= 1'b0;
        end else begin
            state     <= state_next;
            frame_err <= err_next;
            nd_prev   <= nextdata_n;
            if (push && full && !pop)
                overflow <= 1'b1;
            if (state == IDLE && fall && !din)
                bitcnt <= 4'd1;
            else if (state == SHIFT && fall)
                bitcnt <= bitcnt + 4'd1;
            // Timeout only runs while a frame is in progress and saturates at the limit.
            if (state != SHIFT || fall)
                tcnt <= '0;
            else if (tcnt != TMO_MAX)
                tcnt <= tcnt + 17'd1;
        end
    end

    // Bits arrive LSB first, so after the stop bit the register holds {stop, parity, data}.
    always_ff @(posedge clk) begin
        if (state == SHIFT && fall)
            shreg <= {din, shreg[9:1]};
    end

    sync_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .clr   (clr),
        .wr_en (push),
        .rd_en (pop),
        .din   (shreg[7:0]),
        .full  (full),
        .empty (empty),
        .dout  (head)
    );

    assign ready = ~empty;
    assign data  = ready ? head : 8'h00;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Randomised bench for ps2_rx_fifo against a queue-based model of the receive path.
module tb_ps2_rx_fifo;

    localparam int TMO  = 400;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       clr;
    logic       ps2_clk;
    logic       ps2_data;
    logic       nextdata_n;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic       frame_err;

    ps2_rx_fifo #(
        .DEPTH_LOG2 (3),
        .TIMEOUT    (TMO)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .nextdata_n (nextdata_n),
        .data       (data),
        .ready      (ready),
        .overflow   (overflow),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int err_seen = 0;
    int err_exp = 0;
    int cyc = 0;
    int err_cyc = 0;
    int fall_cyc = 0;
    logic [7:0] q[$];
    bit ovf_exp = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (frame_err) begin
            err_seen <= err_seen + 1;
            err_cyc  <= cyc;
        end
    end

    task automatic check(string tag, int got, int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_state(string tag);
        check({tag, ".ready"}, ready, (q.size() > 0) ? 1 : 0);
        check({tag, ".data"}, data, (q.size() > 0) ? int'(q[0]) : 0);
        check({tag, ".ovf"}, overflow, ovf_exp);
        check({tag, ".err"}, err_seen, err_exp);
    endtask

    task automatic cycles(int n);
        repeat (n) @(negedge clk);
    endtask

    // Sends the first nbits of a frame; full frames update the model afterwards.
    task automatic send_frame(logic [7:0] b, bit bad_par, int nbits, bit pop_at_stop, bit chk_lat);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2_data = f[i];
            cycles(HALF);
            ps2_clk  = 1'b0;
            fall_cyc = cyc;
            for (int k = 1; k <= HALF; k++) begin
                @(negedge clk);
                if (i == 10 && k == 3) begin
                    if (chk_lat) check("lat.before", ready, 0);
                    if (pop_at_stop) nextdata_n = 1'b0;
                end
                if (i == 10 && k == 4 && chk_lat) check("lat.after", ready, 1);
            end
            ps2_clk    = 1'b1;
            nextdata_n = 1'b1;
        end
        ps2_data = 1'b1;
        if (nbits == 11) begin
            if (pop_at_stop && q.size() > 0) void'(q.pop_front());
            if (!bad_par) begin
                if (q.size() < 8) q.push_back(b);
                else ovf_exp = 1'b1;
            end else begin
                err_exp++;
            end
        end
    endtask

    task automatic pop(int hold, string tag);
        @(negedge clk);
        if (q.size() > 0) begin
            check({tag, ".head"}, data, q[0]);
            void'(q.pop_front());
        end
        nextdata_n = 1'b0;
        cycles(hold);
        nextdata_n = 1'b1;
        cycles(2);
        check_state(tag);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        int d;
        clr = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; nextdata_n = 1'b1;
        cycles(3);
        check("rst.ready", ready, 0);
        check("rst.data", data, 0);
        check("rst.ovf", overflow, 0);
        check("rst.err", frame_err, 0);
        clr = 1'b0;
        cycles(5);

        // Single good frame, latency, one pop per long low pulse
        send_frame(8'h1C, 1'b0, 11, 1'b0, 1'b1);
        check_state("good");
        pop(1000, "good.pop");

        // Break prefix then code
        send_frame(8'hF0, 1'b0, 11, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 11, 1'b0, 1'b0);
        check_state("rel");
        pop(300, "rel.pop1");
        pop(5, "rel.pop2");
        pop(5, "rel.pop_empty");

        // Parity error followed by a good frame
        send_frame(8'h1C, 1'b1, 11, 1'b0, 1'b0);
        check_state("par");
        send_frame(8'h58, 1'b0, 11, 1'b0, 1'b0);
        check_state("par.next");
        pop(3, "par.pop");

        // Full FIFO with a pop landing on the push cycle
        for (int i = 0; i < 8; i++) send_frame(8'($urandom_range(0, 255)), 1'b0, 11, 1'b0, 1'b0);
        check_state("full");
        send_frame(8'($urandom_range(0, 255)), 1'b0, 11, 1'b1, 1'b0);
        check_state("full.simul");
        for (int i = 0; i < 8; i++) pop(2, "full.drain");

        // Overflow on the ninth frame
        for (int i = 0; i < 9; i++) send_frame(8'($urandom_range(0, 255)), 1'b0, 11, 1'b0, 1'b0);
        check_state("ovf");
        for (int i = 0; i < 8; i++) pop(2, "ovf.drain");

        // Timeout of a partial frame
        send_frame(8'hA5, 1'b0, 5, 1'b0, 1'b0);
        cycles(TMO + 30);
        err_exp++;
        check_state("tmo");
        d = err_cyc - fall_cyc;
        check("tmo.window", (d >= TMO && d <= TMO + 8) ? 1 : 0, 1);
        send_frame(8'h3B, 1'b0, 11, 1'b0, 1'b0);
        check_state("tmo.next");

        // Reset mid-frame with queued data and overflow set
        send_frame(8'h22, 1'b0, 11, 1'b0, 1'b0);
        send_frame(8'h6C, 1'b0, 5, 1'b0, 1'b0);
        @(negedge clk);
        clr = 1'b1;
        cycles(1);
        check("clr.ready", ready, 0);
        check("clr.data", data, 0);
        check("clr.ovf", overflow, 0);
        check("clr.err", frame_err, 0);
        q.delete();
        ovf_exp = 1'b0;
        clr = 1'b0;
        cycles(TMO + 30);
        check_state("clr.quiet");
        send_frame(8'h71, 1'b0, 11, 1'b0, 1'b0);
        check_state("clr.next");

        // Random mix of good frames, bad frames and pops
        for (int it = 0; it < 25; it++) begin
            case ($urandom_range(0, 3))
                0, 1: begin
                    b = 8'($urandom_range(0, 255));
                    send_frame(b, 1'b0, 11, 1'b0, 1'b0);
                    check_state("rnd.good");
                end
                2: begin
                    b = 8'($urandom_range(0, 255));
                    send_frame(b, 1'b1, 11, 1'b0, 1'b0);
                    check_state("rnd.bad");
                end
                default: pop($urandom_range(1, 30), "rnd.pop");
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
